// File: rtl/stopwatch_ctrl_if.sv
// Counter-side bundle of the stopwatch controller.
// master = controller, slave = counter/display path.
interface stopwatch_ctrl_if;
  logic       init_regs;
  logic       count_enabled;
  logic [7:0] time_reading;
  logic [7:0] disp_reading;
  logic       lap_active;

  modport master (
    output init_regs,
    output count_enabled,
    output disp_reading,
    output lap_active,
    input  time_reading
  );

  modport slave (
    input  init_regs,
    input  count_enabled,
    input  disp_reading,
    input  lap_active,
    output time_reading
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch UI controller: button sync/debounce, IDLE/RUN/PAUSE FSM.
// Optional lap-freeze display feature enabled by defining LAP_EN.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start,
  input  logic btn_clear,
  input  logic btn_lap,
  stopwatch_ctrl_if.master cnt_if
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

`ifdef LAP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] s1;
  logic [NB-1:0] s2;
  logic [NB-1:0] stable;
  logic [NB-1:0] press;
  logic [CW-1:0] cnt [NB];

  state_t state;
  state_t state_next;

  logic start_p;
  logic clear_p;

`ifdef LAP_EN
  assign raw = {btn_lap, btn_clear, btn_start};
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign raw = {btn_clear, btn_start};
`endif

  assign start_p = press[0];
  assign clear_p = press[1];

  // press fires on the same edge the stable level rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= '0;
      for (int i = 0; i < NB; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]    <= '0;
          stable[i] <= s2[i];
          press[i]  <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_p) state_next = RUN;
      end
      RUN: begin
        if (start_p) state_next = PAUSE;
      end
      PAUSE: begin
        if (clear_p)      state_next = IDLE;
        else if (start_p) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cnt_if.init_regs     = (state == IDLE);
  assign cnt_if.count_enabled = (state == RUN);

`ifdef LAP_EN
  logic       lap_p;
  logic       lap_q;
  logic [7:0] lap_val;

  assign lap_p = press[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q   <= 1'b0;
      lap_val <= 8'h00;
    end else if (state_next == IDLE) begin
      lap_q <= 1'b0;
    end else if (lap_p) begin
      if (lap_q) begin
        lap_q <= 1'b0;
      end else if (state == RUN) begin
        lap_q   <= 1'b1;
        lap_val <= cnt_if.time_reading;
      end
    end
  end

  assign cnt_if.lap_active   = lap_q;
  assign cnt_if.disp_reading =
    lap_q ? lap_val : cnt_if.time_reading;
`else
  assign cnt_if.lap_active   = 1'b0;
  assign cnt_if.disp_reading = cnt_if.time_reading;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: window-based debounce model plus directed checks.
// Build with or without LAP_EN; expectations follow the same define.
module tb_stopwatch_ctrl;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_start = 1'b0;
  logic btn_clear = 1'b0;
  logic btn_lap = 1'b0;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl_if sif ();

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .btn_lap   (btn_lap),
    .cnt_if    (sif.master)
  );

  always #5 clk = ~clk;

`ifdef LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  // Model: a button level is accepted once the D raw samples taken
  // two to D+1 edges ago all disagree with the accepted level; the
  // resulting press moves the mode on the following edge.
  int         m_mode;
  bit         m_lap;
  logic [7:0] m_latch;
  bit         m_stab [3];
  bit         m_pend [3];
  bit         m_hist [3][D+2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  = 0;
      m_lap   = 1'b0;
      m_latch = 8'h00;
      for (int b = 0; b < 3; b++) begin
        m_stab[b] = 1'b0;
        m_pend[b] = 1'b0;
        for (int i = 0; i < D + 2; i++) m_hist[b][i] = 1'b0;
      end
    end else begin
      int  old;
      bit  lp;
      bit  smp [3];
      old = m_mode;
      lp  = m_pend[2] && LAP;
      if (old == 2 && m_pend[1]) m_mode = 0;
      else if (m_pend[0]) m_mode = (old == 1) ? 2 : 1;
      if (m_mode == 0) begin
        m_lap = 1'b0;
      end else if (lp) begin
        if (m_lap) begin
          m_lap = 1'b0;
        end else if (old == 1) begin
          m_lap   = 1'b1;
          m_latch = sif.time_reading;
        end
      end
      smp[0] = btn_start;
      smp[1] = btn_clear;
      smp[2] = btn_lap;
      for (int b = 0; b < 3; b++) begin
        bit all_diff;
        for (int i = D + 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
        m_hist[b][0] = smp[b];
        all_diff = 1'b1;
        for (int i = 2; i < D + 2; i++)
          if (m_hist[b][i] == m_stab[b]) all_diff = 1'b0;
        m_pend[b] = 1'b0;
        if (all_diff) begin
          m_stab[b] = ~m_stab[b];
          m_pend[b] = m_stab[b];
        end
      end
    end
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_init", 8'(sif.init_regs), 8'(m_mode == 0));
    chk("m_en", 8'(sif.count_enabled), 8'(m_mode == 1));
    chk("m_lapact", 8'(sif.lap_active), 8'(m_lap));
    chk("m_disp", sif.disp_reading, m_lap ? m_latch : sif.time_reading);
  end

  task automatic wait_edges(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_btn(int which, logic v);
    case (which)
      0: btn_start = v;
      1: btn_clear = v;
      default: btn_lap = v;
    endcase
  endtask

  task automatic press_btn(int which);
    set_btn(which, 1'b1);
    wait_edges(8);
    set_btn(which, 1'b0);
    wait_edges(8);
  endtask

  task automatic lit(string name, logic init, logic en);
    chk({name, "_init"}, 8'(sif.init_regs), 8'(init));
    chk({name, "_en"}, 8'(sif.count_enabled), 8'(en));
  endtask

  initial begin
    sif.time_reading = 8'h00;
    wait_edges(2);
    lit("reset", 1'b1, 1'b0);
    chk("reset_lap", 8'(sif.lap_active), 8'h00);
    rst_n = 1'b1;
    wait_edges(2);

    // bounce shorter than the debounce window
    for (int i = 0; i < 15; i++) begin
      btn_start = ~btn_start;
      wait_edges(2);
    end
    btn_start = 1'b0;
    wait_edges(10);
    lit("bounce", 1'b1, 1'b0);

    // clean press: RUN appears on the 7th edge counting the first sample
    btn_start = 1'b1;
    wait_edges(6);
    lit("lat_pre", 1'b1, 1'b0);
    wait_edges(1);
    lit("lat_run", 1'b0, 1'b1);
    wait_edges(5);
    btn_start = 1'b0;
    wait_edges(12);
    lit("release", 1'b0, 1'b1);

    press_btn(1);
    lit("run_clr", 1'b0, 1'b1);
    press_btn(0);
    lit("pause", 1'b0, 1'b0);
    press_btn(1);
    lit("clr_idle", 1'b1, 1'b0);

    // simultaneous start+clear in PAUSE
    press_btn(0);
    press_btn(0);
    lit("pause2", 1'b0, 1'b0);
    btn_start = 1'b1;
    btn_clear = 1'b1;
    wait_edges(6);
    lit("both_pre", 1'b0, 1'b0);
    wait_edges(1);
    lit("both_idle", 1'b1, 1'b0);
    btn_start = 1'b0;
    btn_clear = 1'b0;
    wait_edges(10);
    lit("both_hold", 1'b1, 1'b0);

    // lap freeze
    press_btn(0);
    sif.time_reading = 8'h12;
    btn_lap = 1'b1;
    wait_edges(7);
    chk("lap1_act", 8'(sif.lap_active), 8'(LAP));
    for (int t = 13; t <= 15; t++) begin
      sif.time_reading = 8'(t + 6 * (t / 10));
      wait_edges(3);
      chk("lap_hold", sif.disp_reading, LAP ? 8'h12 : sif.time_reading);
    end
    chk("lap_tr15", sif.time_reading, 8'h15);
    btn_lap = 1'b0;
    wait_edges(8);
    btn_lap = 1'b1;
    wait_edges(7);
    chk("lap2_disp", sif.disp_reading, 8'h15);
    chk("lap2_act", 8'(sif.lap_active), 8'h00);
    btn_lap = 1'b0;
    wait_edges(8);

    // lap together with start: latch and pause on the same edge
    btn_lap = 1'b1;
    btn_start = 1'b1;
    wait_edges(7);
    lit("lapstart", 1'b0, 1'b0);
    btn_lap = 1'b0;
    btn_start = 1'b0;
    sif.time_reading = 8'h16;
    wait_edges(8);
    chk("lapst_disp", sif.disp_reading, LAP ? 8'h15 : 8'h16);
    press_btn(2);
    chk("pause_unlap", 8'(sif.lap_active), 8'h00);
    press_btn(1);
    lit("lap_idle", 1'b1, 1'b0);

    // reset in the middle of RUN
    press_btn(0);
    lit("pre_rst", 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    lit("async_rst", 1'b1, 1'b0);
    chk("rst_lap", 8'(sif.lap_active), 8'h00);
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(20);
    lit("post_rst", 1'b1, 1'b0);

    // button held through reset release
    btn_start = 1'b1;
    wait_edges(2);
    rst_n = 1'b0;
    wait_edges(3);
    rst_n = 1'b1;
    wait_edges(6);
    lit("held_pre", 1'b1, 1'b0);
    wait_edges(1);
    lit("held_run", 1'b0, 1'b1);
    btn_start = 1'b0;
    wait_edges(12);
    lit("held_end", 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
